uart_master: RTL and testbench

Bus initiator that drives the memory-mapped UART register block (data at +0, rx-waiting flag at +2, tx-ready flag at +4) with no CPU involved. It polls the receive flag, fetches and acknowledges received bytes, and drains a local transmit FIFO into the UART. The terminal logic uses it through two valid/ready byte streams.

---
 rtl/uart_master.sv | 250 +++++++++++++++++++++++++
 tb/tb_uart_master.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_master.sv
// uart_master: bus initiator for a memory-mapped UART register block.
// It polls the receive flag, fetches and acknowledges received bytes, and
// drains a local transmit FIFO into the UART. RX and TX sides are served
// strictly round-robin; a side with nothing to do is skipped.
//
// Register map relative to BASE: +0 data, +2 rx-waiting flag, +4 tx-ready flag.
//
// Parameters:
//   BASE        base address of the UART block (BASE[3:0] must be 0)
//   TXDEPTH     transmit FIFO depth (power of two, >= 2)
//   TX_HOLDOFF  idle cycles after a data write before txready is polled (>= 2)
//
// Ports:
//   clk, rst_n         clock (rising edge), asynchronous active-low reset
//   addr, mout, bwe    bus address, write data {8'h00, byte}, byte enables
//   min                registered read data, valid one cycle after addr
//   tx_data/valid/ready  byte stream into the transmit FIFO
//   rx_data/valid/ready  received byte stream to the consumer
//   rx_count, tx_count   byte counters
//
// Optional feature: define UART_MASTER_STATS_EN to build the 16-bit wrapping
// rx/tx byte counters; otherwise both outputs are tied to zero.

module uart_master #(
    parameter logic [15:0] BASE       = 16'h0000,
    parameter int unsigned TXDEPTH    = 16,
    parameter int unsigned TX_HOLDOFF = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [15:0] addr,
    output logic [15:0] mout,
    input  logic [15:0] min,
    output logic [1:0]  bwe,
    input  logic [7:0]  tx_data,
    input  logic        tx_valid,
    output logic        tx_ready,
    output logic [7:0]  rx_data,
    output logic        rx_valid,
    input  logic        rx_ready,
    output logic [15:0] rx_count,
    output logic [15:0] tx_count
);

    localparam int unsigned AW = $clog2(TXDEPTH);
    localparam int unsigned PW = AW + 1;
    localparam int unsigned HW = $clog2(TX_HOLDOFF);

    localparam logic [15:0] ADDR_DATA = BASE;
    localparam logic [15:0] ADDR_RXW  = 16'(BASE + 16'd2);
    localparam logic [15:0] ADDR_TXR  = 16'(BASE + 16'd4);

    typedef enum logic [3:0] {
        RX_POLL,
        RX_CHK,
        RX_READ,
        RX_CAP,
        RX_CLR,
        TX_POLL,
        TX_CHK,
        TX_WR,
        TX_WAIT
    } state_e;

    state_e          state_q, state_d;
    logic [HW-1:0]   hold_q, hold_d;
    logic [15:0]     addr_q, addr_d;
    logic [15:0]     mout_q, mout_d;
    logic [1:0]      bwe_q, bwe_d;

    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [7:0]      mem_q [TXDEPTH];
    logic            tx_ready_q, tx_ready_d;
    logic            fifo_empty;
    logic            full_d;
    logic            push, pop;
    logic [7:0]      head;

    logic            rx_valid_q, rx_valid_d;
    logic [7:0]      rx_data_q, rx_data_d;

    state_e          rx_side, tx_side;

    logic [7:0]      unused_min;
    assign unused_min = min[15:8];

    // FIFO status and handshakes
    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign push       = tx_valid && tx_ready_q;
    assign pop        = (state_q == TX_WR);
    assign head       = mem_q[rd_ptr_q[AW-1:0]];

    // Entry points of each side; a side with nothing to do hands over
    // to the other one, and with both idle the FSM rests in RX_POLL.
    assign tx_side = fifo_empty ? RX_POLL : TX_POLL;
    assign rx_side = rx_valid_q ? tx_side : RX_POLL;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RX_POLL;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
        end
    end

    // Next-state logic and bus decode of the upcoming state
    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        addr_d  = ADDR_RXW;
        mout_d  = 16'h0000;
        bwe_d   = 2'b00;

        case (state_q)
            RX_POLL: state_d = rx_valid_q ? tx_side : RX_CHK;
            RX_CHK:  state_d = min[0] ? RX_READ : tx_side;
            RX_READ: state_d = RX_CAP;
            RX_CAP:  state_d = RX_CLR;
            RX_CLR:  state_d = tx_side;
            TX_POLL: state_d = TX_CHK;
            TX_CHK:  state_d = min[0] ? TX_WR : rx_side;
            TX_WR: begin
                state_d = TX_WAIT;
                hold_d  = HW'(TX_HOLDOFF - 1);
            end
            TX_WAIT: begin
                if (hold_q == '0) begin
                    state_d = rx_side;
                end else begin
                    hold_d = hold_q - HW'(1);
                end
            end
            default: state_d = RX_POLL;
        endcase

        // Head is stable until the pop in TX_WR, so it is safe to latch here.
        case (state_d)
            RX_READ: addr_d = ADDR_DATA;
            RX_CLR:  bwe_d  = 2'b01;
            TX_POLL: addr_d = ADDR_TXR;
            TX_WR: begin
                addr_d = ADDR_DATA;
                mout_d = {8'h00, head};
                bwe_d  = 2'b01;
            end
            default: ;
        endcase
    end

    // Bus output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q <= ADDR_RXW;
            mout_q <= 16'h0000;
            bwe_q  <= 2'b00;
        end else begin
            addr_q <= addr_d;
            mout_q <= mout_d;
            bwe_q  <= bwe_d;
        end
    end

    // FIFO pointer update; ready stays high in a pop cycle so that a push
    // into a full FIFO can pair with the pop.
    always_comb begin
        wr_ptr_d   = push ? PW'(wr_ptr_q + PW'(1)) : wr_ptr_q;
        rd_ptr_d   = pop  ? PW'(rd_ptr_q + PW'(1)) : rd_ptr_q;
        full_d     = ((wr_ptr_d ^ rd_ptr_d) == {1'b1, {AW{1'b0}}});
        tx_ready_d = !full_d || (state_d == TX_WR);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            tx_ready_q <= 1'b1;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            tx_ready_q <= tx_ready_d;
        end
    end

    // FIFO storage, contents are qualified by the pointers only
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= tx_data;
        end
    end

    // Receive holding register; RX_CAP only happens while rx_valid is low.
    always_comb begin
        rx_valid_d = rx_valid_q;
        rx_data_d  = rx_data_q;
        if (rx_valid_q && rx_ready) begin
            rx_valid_d = 1'b0;
        end
        if (state_q == RX_CAP) begin
            rx_valid_d = 1'b1;
            rx_data_d  = min[7:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_valid_q <= 1'b0;
            rx_data_q  <= 8'h00;
        end else begin
            rx_valid_q <= rx_valid_d;
            rx_data_q  <= rx_data_d;
        end
    end

`ifdef UART_MASTER_STATS_EN
    logic [15:0] rx_count_q, tx_count_q;

    // Byte counters, wrapping
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_count_q <= 16'h0000;
            tx_count_q <= 16'h0000;
        end else begin
            if (state_q == RX_CAP) begin
                rx_count_q <= rx_count_q + 16'd1;
            end
            if (state_q == TX_WR) begin
                tx_count_q <= tx_count_q + 16'd1;
            end
        end
    end

    assign rx_count = rx_count_q;
    assign tx_count = tx_count_q;
`else
    assign rx_count = 16'h0000;
    assign tx_count = 16'h0000;
`endif

    assign addr     = addr_q;
    assign mout     = mout_q;
    assign bwe      = bwe_q;
    assign tx_ready = tx_ready_q;
    assign rx_valid = rx_valid_q;
    assign rx_data  = rx_data_q;

endmodule

// File: tb/tb_uart_master.sv
// Directed bench for uart_master with a behavioural UART register model.
module tb_uart_master;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] addr;
    logic [15:0] mout;
    logic [15:0] min = 16'h0000;
    logic [1:0]  bwe;
    logic [7:0]  tx_data = 8'h00;
    logic        tx_valid = 1'b0;
    logic        tx_ready;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready = 1'b0;
    logic [15:0] rx_count;
    logic [15:0] tx_count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    uart_master #(
        .BASE       (16'h0000),
        .TXDEPTH    (16),
        .TX_HOLDOFF (4)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .addr     (addr),
        .mout     (mout),
        .min      (min),
        .bwe      (bwe),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_ready (rx_ready),
        .rx_count (rx_count),
        .tx_count (tx_count)
    );

    // UART register model: registered reads, write to +2 clears rxwaiting
    logic        rxwaiting = 1'b0;
    logic [7:0]  rxbyte = 8'h00;
    logic        txready_m = 1'b0;
    logic        set_rx = 1'b0;
    logic [7:0]  set_byte = 8'h00;
    int          cyc = 0;
    int          n_wr = 0;
    int          n_clr = 0;
    int          n_rd0 = 0;
    logic [15:0] log_d[$];
    int          log_t[$];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        case (addr)
            16'h0000: min <= {8'h00, rxbyte};
            16'h0002: min <= {15'h0000, rxwaiting};
            16'h0004: min <= {15'h0000, txready_m};
            default:  min <= 16'h0000;
        endcase
        if (bwe == 2'b00 && addr == 16'h0000) n_rd0 <= n_rd0 + 1;
        if (bwe != 2'b00) n_wr <= n_wr + 1;
        if (bwe == 2'b01 && addr == 16'h0002) begin
            n_clr     <= n_clr + 1;
            rxwaiting <= 1'b0;
        end
        if (bwe == 2'b01 && addr == 16'h0000) begin
            log_d.push_back(mout);
            log_t.push_back(cyc);
        end
        if (set_rx) begin
            rxwaiting <= 1'b1;
            rxbyte    <= set_byte;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_rxv(input int budget, output logic ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (rx_valid) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_logs(input int n, input int budget, output logic ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (log_d.size() >= n) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic uart_rx(input logic [7:0] b);
        set_byte = b;
        set_rx   = 1'b1;
        @(negedge clk);
        set_rx   = 1'b0;
    endtask

    task automatic push_byte(input logic [7:0] b);
        tx_valid = 1'b1;
        tx_data  = b;
        @(negedge clk);
        tx_valid = 1'b0;
    endtask

    task automatic consume();
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        logic ok;
        int   base;
        int   w0;
        int   r0;
        int   c0;

        // Reset
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_bwe",      32'(bwe),      0);
        chk("reset_addr",     32'(addr),     32'h0002);
        chk("reset_mout",     32'(mout),     0);
        chk("reset_tx_ready", 32'(tx_ready), 1);
        chk("reset_rx_valid", 32'(rx_valid), 0);
        chk("reset_rx_data",  32'(rx_data),  0);
        chk("reset_rx_count", 32'(rx_count), 0);
        chk("reset_tx_count", 32'(tx_count), 0);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        chk("idle_no_write", 32'(n_wr), 0);

        // RX single byte
        c0 = n_clr;
        uart_rx(8'h5A);
        wait_rxv(20, ok);
        chk("rx5a_seen", 32'(ok), 1);
        chk("rx5a_data", 32'(rx_data), 32'h5A);
        repeat (10) @(negedge clk);
        chk("rx5a_one_clear", 32'(n_clr - c0), 1);
        chk("rx5a_flag_clr",  32'(rxwaiting), 0);
        chk("rx5a_held",      32'(rx_valid), 1);
`ifdef UART_MASTER_STATS_EN
        chk("rx5a_count", 32'(rx_count), 1);
`else
        chk("rx5a_count", 32'(rx_count), 0);
`endif
        consume();
        chk("rx5a_consumed", 32'(rx_valid), 0);

        // RX backpressure
        uart_rx(8'h11);
        wait_rxv(20, ok);
        chk("bp11_seen", 32'(ok), 1);
        chk("bp11_data", 32'(rx_data), 32'h11);
        r0 = n_rd0;
        uart_rx(8'h22);
        repeat (40) @(negedge clk);
        chk("bp_hold_data",  32'(rx_data), 32'h11);
        chk("bp_hold_valid", 32'(rx_valid), 1);
        chk("bp_no_read",    32'(n_rd0 - r0), 0);
        chk("bp_flag_kept",  32'(rxwaiting), 1);
        consume();
        wait_rxv(20, ok);
        chk("bp22_seen", 32'(ok), 1);
        chk("bp22_data", 32'(rx_data), 32'h22);
        consume();

        // TX burst: fill the FIFO while the UART is busy, then release
        w0   = n_wr;
        base = log_d.size();
        for (int i = 0; i < 16; i++) begin
            chk("burst_ready", 32'(tx_ready), 1);
            push_byte(8'(8'h41 + i));
        end
        chk("burst_full", 32'(tx_ready), 0);
        repeat (10) @(negedge clk);
        chk("burst_no_write", 32'(n_wr - w0), 0);
        txready_m = 1'b1;
        wait_logs(base + 16, 1000, ok);
        chk("burst_done", 32'(ok), 1);
        for (int i = 0; i < 16; i++) begin
            chk("burst_data", 32'(log_d[base + i]), 32'(8'h41 + i));
            if (i > 0) begin
                chk("burst_spacing", 32'(log_t[base + i] - log_t[base + i - 1] >= 7), 1);
            end
        end
`ifdef UART_MASTER_STATS_EN
        chk("burst_tx_count", 32'(tx_count), 16);
`else
        chk("burst_tx_count", 32'(tx_count), 0);
`endif
        chk("burst_ready_after", 32'(tx_ready), 1);

        // TX stall
        txready_m = 1'b0;
        repeat (4) @(negedge clk);
        w0   = n_wr;
        base = log_d.size();
        push_byte(8'h61);
        push_byte(8'h62);
        push_byte(8'h63);
        repeat (40) @(negedge clk);
        chk("stall_no_bwe", 32'(n_wr - w0), 0);
        txready_m = 1'b1;
        wait_logs(base + 3, 300, ok);
        chk("stall_done", 32'(ok), 1);
        chk("stall_b0", 32'(log_d[base]),     32'h0061);
        chk("stall_b1", 32'(log_d[base + 1]), 32'h0062);
        chk("stall_b2", 32'(log_d[base + 2]), 32'h0063);

        // Push and pop on a full FIFO, then reset during TX_WAIT
        txready_m = 1'b0;
        repeat (4) @(negedge clk);
        base = log_d.size();
        for (int i = 0; i < 16; i++) push_byte(8'(8'h70 + i));
        tx_valid = 1'b1;
        tx_data  = 8'h80;
        chk("pp_full", 32'(tx_ready), 0);
        txready_m = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (bwe == 2'b01 && addr == 16'h0000) begin
                ok = 1'b1;
                break;
            end
        end
        chk("pp_found",        32'(ok), 1);
        chk("pp_ready_on_pop", 32'(tx_ready), 1);
        chk("pp_mout",         32'(mout), 32'h0070);
        @(negedge clk);
        tx_valid = 1'b0;
        chk("pp_still_full", 32'(tx_ready), 0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_addr",     32'(addr),     32'h0002);
        chk("rst_bwe",      32'(bwe),      0);
        chk("rst_mout",     32'(mout),     0);
        chk("rst_tx_ready", 32'(tx_ready), 1);
        chk("rst_rx_valid", 32'(rx_valid), 0);
        chk("rst_rx_data",  32'(rx_data),  0);
        chk("rst_rx_count", 32'(rx_count), 0);
        chk("rst_tx_count", 32'(tx_count), 0);
        chk("pp_one_write", 32'(log_d.size() - base), 1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        w0 = n_wr;
        repeat (60) @(negedge clk);
        chk("post_rst_no_write", 32'(n_wr - w0), 0);
        chk("post_rst_ready",    32'(tx_ready), 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
